// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined channel multiplexer.
// Mode encodings plus the channel-index width helper.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_pipe_rr_arbiter.sv
// Round-robin grant search starting at a rotating pointer.
// Pointer moves past the granted channel only when it is accepted.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = chan_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW-1:0] r_ptr;
  int            w_idx;

  // Walk downwards so the lowest offset from r_ptr wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (req[w_idx]) begin
        grant       = SW'(w_idx);
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// N-to-1 channel multiplexer with a single registered output stage.
// Channel chosen by sel or by round-robin arbitration.
module mux_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MODE_SEL,
  localparam int SW   = chan_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0]    w_g;
  logic             w_gv;
  logic             w_free;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_chan;
  logic             r_valid;

  assign w_free = !r_valid || out_ready;
  assign w_xfer = w_gv && w_free && !rst && in_valid[w_g];
  assign w_data = in_data[int'(w_g)*WIDTH +: WIDTH];

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic w_unused_sel;
      assign w_unused_sel = ^sel;
      rr_arbiter #(.N(N)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .advance     (w_xfer),
        .grant       (w_g),
        .grant_valid (w_gv)
      );
    end else begin : g_sel
      assign w_g  = sel;
      assign w_gv = int'(sel) < N;
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    if (w_gv && w_free && !rst) in_ready[w_g] = 1'b1;
  end

  // Data/chan keep their last value when the word drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_data;
      r_chan  <= w_g;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench: SEL N=2, SEL N=3 and RR N=4 instances.
// Vector tables plus hand sequences for stall and async reset.
module tb_mux_pipe;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] s2_in_data;
  logic [1:0]  s2_in_valid, s2_in_ready;
  logic        s2_sel, s2_out_chan, s2_out_valid, s2_out_ready;
  logic [31:0] s2_out_data;

  logic [95:0] s3_in_data;
  logic [2:0]  s3_in_valid, s3_in_ready;
  logic [1:0]  s3_sel, s3_out_chan;
  logic        s3_out_valid, s3_out_ready;
  logic [31:0] s3_out_data;

  logic [127:0] rr_in_data;
  logic [3:0]  rr_in_valid, rr_in_ready;
  logic [1:0]  rr_sel, rr_out_chan;
  logic        rr_out_valid, rr_out_ready;
  logic [31:0] rr_out_data;

  mux_pipe #(.WIDTH(32), .N(2), .MODE(MODE_SEL)) u_s2 (
    .clk(clk), .rst(rst), .in_data(s2_in_data),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready),
    .sel(s2_sel), .out_data(s2_out_data),
    .out_chan(s2_out_chan), .out_valid(s2_out_valid),
    .out_ready(s2_out_ready));

  mux_pipe #(.WIDTH(32), .N(3), .MODE(MODE_SEL)) u_s3 (
    .clk(clk), .rst(rst), .in_data(s3_in_data),
    .in_valid(s3_in_valid), .in_ready(s3_in_ready),
    .sel(s3_sel), .out_data(s3_out_data),
    .out_chan(s3_out_chan), .out_valid(s3_out_valid),
    .out_ready(s3_out_ready));

  mux_pipe #(.WIDTH(32), .N(4), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst), .in_data(rr_in_data),
    .in_valid(rr_in_valid), .in_ready(rr_in_ready),
    .sel(rr_sel), .out_data(rr_out_data),
    .out_chan(rr_out_chan), .out_valid(rr_out_valid),
    .out_ready(rr_out_ready));

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [31:0] d0, d1;
    logic [1:0]  v, rdy;
    logic        xfer;
    logic [31:0] ed;
    logic        ec;
  } vec_t;

  typedef struct {
    logic [3:0] v, rdy;
    logic       xfer;
    logic [1:0] ec;
  } rr_vec_t;

  exp_t q2[$];
  exp_t qr[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic expect_out(input int id, input string nm,
                            input logic exp_v);
    logic v;
    logic [31:0] d;
    logic [1:0] c;
    exp_t e;
    if (id == 0) begin
      v = s2_out_valid; d = s2_out_data; c = {1'b0, s2_out_chan};
    end else begin
      v = rr_out_valid; d = rr_out_data; c = rr_out_chan;
    end
    chk({nm, ".valid"}, 64'(v), 64'(exp_v));
    if (exp_v) begin
      if ((id == 0 && q2.size() == 0) || (id != 0 && qr.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s: output with empty scoreboard", nm);
      end else begin
        if (id == 0) e = q2.pop_front();
        else e = qr.pop_front();
        chk({nm, ".data"}, 64'(d), 64'(e.d));
        chk({nm, ".chan"}, 64'(c), 64'(e.c));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[6];
    rr_vec_t rtab[10];
    logic [31:0] last_d;
    logic last_c;
    exp_t e;

    tab[0] = '{1'b0, 32'h0000FFFF, 32'h0, 2'b11, 2'b01, 1'b1, 32'h0000FFFF, 1'b0};
    tab[1] = '{1'b1, 32'h0000FFFF, 32'h0, 2'b11, 2'b10, 1'b1, 32'h00000000, 1'b1};
    tab[2] = '{1'b0, 32'h11111111, 32'h0, 2'b10, 2'b01, 1'b0, 32'h0, 1'b0};
    tab[3] = '{1'b1, 32'h0, 32'hDEADBEEF, 2'b10, 2'b10, 1'b1, 32'hDEADBEEF, 1'b1};
    tab[4] = '{1'b1, 32'h22222222, 32'h0, 2'b01, 2'b10, 1'b0, 32'h0, 1'b0};
    tab[5] = '{1'b0, 32'h13579BDF, 32'h0, 2'b01, 2'b01, 1'b1, 32'h13579BDF, 1'b0};

    rtab[0] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    rtab[1] = '{4'b1111, 4'b0010, 1'b1, 2'd1};
    rtab[2] = '{4'b1111, 4'b0100, 1'b1, 2'd2};
    rtab[3] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
    rtab[4] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    rtab[5] = '{4'b0100, 4'b0100, 1'b1, 2'd2};
    rtab[6] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    rtab[7] = '{4'b0101, 4'b0001, 1'b1, 2'd0};
    rtab[8] = '{4'b0101, 4'b0100, 1'b1, 2'd2};
    rtab[9] = '{4'b0101, 4'b0001, 1'b1, 2'd0};

    s2_in_data = {32'h1, 32'h2};
    s2_in_valid = 2'b11;
    s2_sel = 1'b0;
    s2_out_ready = 1'b1;
    s3_in_data = '0;
    s3_in_valid = 3'b111;
    s3_sel = 2'd0;
    s3_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = rr_word(i);
    rr_in_valid = 4'b1111;
    rr_sel = 2'd0;
    rr_out_ready = 1'b1;

    // Reset state, including across clock edges.
    #3;
    chk("rst.s2_valid", 64'(s2_out_valid), 64'd0);
    chk("rst.s2_data", 64'(s2_out_data), 64'd0);
    chk("rst.s2_chan", 64'(s2_out_chan), 64'd0);
    chk("rst.s2_ready", 64'(s2_in_ready), 64'd0);
    chk("rst.s3_ready", 64'(s3_in_ready), 64'd0);
    chk("rst.rr_ready", 64'(rr_in_ready), 64'd0);
    tick;
    tick;
    chk("rst.s2_valid_edge", 64'(s2_out_valid), 64'd0);
    chk("rst.rr_valid_edge", 64'(rr_out_valid), 64'd0);
    rst = 1'b0;
    s3_in_valid = '0;
    rr_in_valid = '0;

    // SEL N=2 table, out_ready held high.
    last_d = '0;
    last_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s2_sel = tab[i].sel;
      s2_in_data = {tab[i].d1, tab[i].d0};
      s2_in_valid = tab[i].v;
      #1;
      chk($sformatf("tab%0d.in_ready", i), 64'(s2_in_ready), 64'(tab[i].rdy));
      if (tab[i].xfer) begin
        e.d = tab[i].ed;
        e.c = {1'b0, tab[i].ec};
        q2.push_back(e);
        last_d = tab[i].ed;
        last_c = tab[i].ec;
      end
      tick;
      expect_out(0, $sformatf("tab%0d", i), tab[i].xfer);
      if (!tab[i].xfer) begin
        chk($sformatf("tab%0d.hold_data", i), 64'(s2_out_data), 64'(last_d));
        chk($sformatf("tab%0d.hold_chan", i), 64'(s2_out_chan), 64'(last_c));
      end
    end
    s2_in_valid = '0;

    // SEL N=3: out-of-range select grants nothing.
    s3_in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    s3_in_valid = 3'b111;
    s3_sel = 2'd3;
    #1;
    chk("s3.sel3_ready", 64'(s3_in_ready), 64'd0);
    tick;
    chk("s3.sel3_valid1", 64'(s3_out_valid), 64'd0);
    tick;
    chk("s3.sel3_valid2", 64'(s3_out_valid), 64'd0);
    s3_sel = 2'd2;
    #1;
    chk("s3.sel2_ready", 64'(s3_in_ready), 64'b100);
    tick;
    chk("s3.sel2_valid", 64'(s3_out_valid), 64'd1);
    chk("s3.sel2_data", 64'(s3_out_data), 64'h33333333);
    chk("s3.sel2_chan", 64'(s3_out_chan), 64'd2);
    s3_in_valid = '0;

    // Stall: held word survives data and sel changes, then no bubble.
    s2_sel = 1'b0;
    s2_in_data = {32'h0, 32'hAAAA5555};
    s2_in_valid = 2'b01;
    e.d = 32'hAAAA5555;
    e.c = 2'd0;
    q2.push_back(e);
    tick;
    expect_out(0, "stall.load", 1'b1);
    s2_out_ready = 1'b0;
    s2_in_data = {32'h0, 32'h12345678};
    for (int i = 0; i < 3; i++) begin
      s2_sel = i[0];
      #1;
      chk($sformatf("stall%0d.in_ready", i), 64'(s2_in_ready), 64'd0);
      tick;
      chk($sformatf("stall%0d.valid", i), 64'(s2_out_valid), 64'd1);
      chk($sformatf("stall%0d.data", i), 64'(s2_out_data), 64'hAAAA5555);
      chk($sformatf("stall%0d.chan", i), 64'(s2_out_chan), 64'd0);
    end
    s2_sel = 1'b0;
    s2_out_ready = 1'b1;
    #1;
    chk("stall.release_ready", 64'(s2_in_ready), 64'b01);
    e.d = 32'h12345678;
    e.c = 2'd0;
    q2.push_back(e);
    tick;
    expect_out(0, "stall.reload", 1'b1);
    s2_in_valid = '0;
    tick;
    expect_out(0, "stall.drain", 1'b0);
    chk("stall.drain_hold", 64'(s2_out_data), 64'h12345678);

    // Round-robin table; sel is randomised and must be ignored.
    for (int i = 0; i < 10; i++) begin
      rr_in_valid = rtab[i].v;
      rr_sel = 2'($urandom_range(3, 0));
      #1;
      chk($sformatf("rr%0d.in_ready", i), 64'(rr_in_ready), 64'(rtab[i].rdy));
      if (rtab[i].xfer) begin
        e.d = rr_word(int'(rtab[i].ec));
        e.c = rtab[i].ec;
        qr.push_back(e);
      end
      tick;
      expect_out(1, $sformatf("rr%0d", i), rtab[i].xfer);
    end

    // Asynchronous reset mid-stall; pointer is at 1 here.
    s2_sel = 1'b1;
    s2_in_data = {32'h55AA55AA, 32'h0};
    s2_in_valid = 2'b10;
    e.d = 32'h55AA55AA;
    e.c = 2'd1;
    q2.push_back(e);
    rr_in_valid = 4'b1111;
    e.d = rr_word(1);
    e.c = 2'd1;
    qr.push_back(e);
    tick;
    expect_out(0, "pre_rst.s2", 1'b1);
    expect_out(1, "pre_rst.rr", 1'b1);
    s2_out_ready = 1'b0;
    rr_out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst.s2_valid", 64'(s2_out_valid), 64'd0);
    chk("arst.s2_data", 64'(s2_out_data), 64'd0);
    chk("arst.s2_chan", 64'(s2_out_chan), 64'd0);
    chk("arst.s2_ready", 64'(s2_in_ready), 64'd0);
    chk("arst.rr_valid", 64'(rr_out_valid), 64'd0);
    chk("arst.rr_data", 64'(rr_out_data), 64'd0);
    chk("arst.rr_chan", 64'(rr_out_chan), 64'd0);
    chk("arst.rr_ready", 64'(rr_in_ready), 64'd0);
    tick;
    rst = 1'b0;
    s2_out_ready = 1'b1;
    rr_out_ready = 1'b1;
    s2_sel = 1'b0;
    s2_in_data = {32'h0, 32'hFEEDF00D};
    s2_in_valid = 2'b01;
    #1;
    chk("post_rst.rr_ready", 64'(rr_in_ready), 64'b0001);
    chk("post_rst.s2_ready", 64'(s2_in_ready), 64'b01);
    e.d = rr_word(0);
    e.c = 2'd0;
    qr.push_back(e);
    e.d = 32'hFEEDF00D;
    q2.push_back(e);
    tick;
    expect_out(1, "post_rst.rr", 1'b1);
    expect_out(0, "post_rst.s2", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
